// File: rtl/lif_neuron_delayed.sv
// Leaky integrate-and-fire neuron with per-synapse programmable spike delays.
// Define LIF_NEURON_DEBUG_EN to expose the registered membrane and current.
module lif_neuron_delayed #(
  parameter int M          = 8,
  parameter int NBITS      = 4,
  parameter int DBITS      = 2,
  parameter int RESET_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [M-1:0]         input_spikes,
  input  logic [M*NBITS-1:0]   weights,
  input  logic [M*DBITS-1:0]   delays,
  input  logic [NBITS-1:0]     threshold,
  input  logic [NBITS-1:0]     decay,
  input  logic [NBITS-1:0]     refractory_period,
`ifdef LIF_NEURON_DEBUG_EN
  output logic [NBITS-1:0]     membrane_potential_out,
  output logic [NBITS-1:0]     input_current_out,
`endif
  output logic                 spike_out
);

  localparam int DEPTH = (1 << DBITS) - 1;
  localparam int AW    = NBITS + $clog2(M + 1);
  localparam logic [NBITS-1:0] MAXV = '1;

  function automatic logic [NBITS-1:0] sat_sum(input logic [AW-1:0] a);
    if (a > AW'(MAXV)) return MAXV;
    return a[NBITS-1:0];
  endfunction

  function automatic logic [NBITS-1:0] sat_add(input logic [NBITS-1:0] a,
                                               input logic [NBITS-1:0] b);
    logic [NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[NBITS] ? MAXV : s[NBITS-1:0];
  endfunction

  logic             hist_p0 [M][DEPTH];
  logic [M-1:0]     dspk_p0;
  logic [AW-1:0]    acc_p0;
  logic [NBITS-1:0] cur_p1;
  logic [NBITS-1:0] mem_p2;
  logic [NBITS-1:0] refr_p2;
  logic             spike_p2;

  logic [NBITS-1:0] sum_p2;
  logic [NBITS-1:0] mem_nxt;
  logic [NBITS-1:0] refr_nxt;
  logic             spike_nxt;

  // Stage 0: delay-tap selection and weighted sum of delayed spikes
  always_comb begin
    logic [DBITS-1:0] dly;
    logic [DBITS-1:0] idx;
    dspk_p0 = '0;
    acc_p0  = '0;
    for (int i = 0; i < M; i++) begin
      dly = delays[i*DBITS +: DBITS];
      idx = dly - DBITS'(1);
      dspk_p0[i] = (dly == '0) ? input_spikes[i] : hist_p0[i][idx];
      if (dspk_p0[i]) acc_p0 = acc_p0 + AW'(weights[i*NBITS +: NBITS]);
    end
  end

  // Stage 2: membrane integrate / fire / leak using last step's current
  always_comb begin
    sum_p2    = sat_add(mem_p2, cur_p1);
    mem_nxt   = '0;
    refr_nxt  = '0;
    spike_nxt = 1'b0;
    if (refr_p2 != '0) begin
      refr_nxt = refr_p2 - NBITS'(1);
    end else if (sum_p2 >= threshold) begin
      spike_nxt = 1'b1;
      refr_nxt  = refractory_period;
      mem_nxt   = (RESET_MODE == 1) ? sum_p2 - threshold : '0;
    end else begin
      mem_nxt   = (sum_p2 > decay) ? sum_p2 - decay : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < M; i++)
        for (int k = 0; k < DEPTH; k++)
          hist_p0[i][k] <= 1'b0;
      cur_p1   <= '0;
      mem_p2   <= '0;
      refr_p2  <= '0;
      spike_p2 <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < M; i++) begin
        for (int k = DEPTH - 1; k >= 1; k--)
          hist_p0[i][k] <= hist_p0[i][k-1];
        hist_p0[i][0] <= input_spikes[i];
      end
      cur_p1   <= sat_sum(acc_p0);
      mem_p2   <= mem_nxt;
      refr_p2  <= refr_nxt;
      spike_p2 <= spike_nxt;
    end
  end

  assign spike_out = spike_p2;

`ifdef LIF_NEURON_DEBUG_EN
  assign membrane_potential_out = mem_p2;
  assign input_current_out      = cur_p1;
`endif

endmodule

// File: tb/tb_lif_neuron_delayed.sv
// Self-checking bench for lif_neuron_delayed: directed scenarios plus a
// randomized run against a step-level behavioural model (both reset modes).
module tb_lif_neuron_delayed;
  localparam int M = 8, NBITS = 4, DBITS = 2;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  spk_in;
  logic [31:0] w;
  logic [15:0] dl;
  logic [3:0]  thr, dec, rp;
  logic        so0, so1;
  int total = 0, bad = 0;

`ifdef LIF_NEURON_DEBUG_EN
  logic [3:0] mp0, ic0, mp1, ic1;
`endif

  lif_neuron_delayed #(.M(M), .NBITS(NBITS), .DBITS(DBITS), .RESET_MODE(0)) dut (
    .clk(clk), .reset(rst), .enable(en), .input_spikes(spk_in), .weights(w),
    .delays(dl), .threshold(thr), .decay(dec), .refractory_period(rp),
`ifdef LIF_NEURON_DEBUG_EN
    .membrane_potential_out(mp0), .input_current_out(ic0),
`endif
    .spike_out(so0));

  lif_neuron_delayed #(.M(M), .NBITS(NBITS), .DBITS(DBITS), .RESET_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .enable(en), .input_spikes(spk_in), .weights(w),
    .delays(dl), .threshold(thr), .decay(dec), .refractory_period(rp),
`ifdef LIF_NEURON_DEBUG_EN
    .membrane_potential_out(mp1), .input_current_out(ic1),
`endif
    .spike_out(so1));

  always #5 clk = ~clk;

  // Behavioural model: one call per rising edge, using the inputs about to be sampled.
  int         m_cur;
  int         m_v[2];
  int         m_refr[2];
  bit         m_spk[2];
  logic [7:0] hq[$];

  task automatic model_update();
    int sum, s, dly;
    logic [7:0] past;
    if (rst) begin
      m_cur = 0;
      for (int m = 0; m < 2; m++) begin m_v[m] = 0; m_refr[m] = 0; m_spk[m] = 0; end
      hq.delete();
      repeat (3) hq.push_back(8'h00);
    end else if (en) begin
      sum = 0;
      for (int i = 0; i < M; i++) begin
        dly = int'(dl[i*2 +: 2]);
        if (dly == 0) past = spk_in;
        else          past = hq[dly-1];
        if (past[i]) sum += int'(w[i*4 +: 4]);
      end
      for (int m = 0; m < 2; m++) begin
        if (m_refr[m] != 0) begin
          m_refr[m]--; m_v[m] = 0; m_spk[m] = 0;
        end else begin
          s = m_v[m] + m_cur;
          if (s > 15) s = 15;
          if (s >= int'(thr)) begin
            m_spk[m] = 1; m_refr[m] = int'(rp);
            m_v[m] = (m == 1) ? s - int'(thr) : 0;
          end else begin
            m_spk[m] = 0;
            m_v[m] = (s > int'(dec)) ? s - int'(dec) : 0;
          end
        end
      end
      m_cur = (sum > 15) ? 15 : sum;
      hq.push_front(spk_in);
      void'(hq.pop_back());
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; spk_in = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; spk_in = '1; w = '1; thr = 4'd0;
    step(); step();
    total++;
    if (so0 !== 1'b0 || so1 !== 1'b0) begin
      bad++; $display("FAIL reset_spike: got %b/%b expected 0/0", so0, so1);
    end
    total++;
    if (dut.mem_p2 !== 4'd0 || dut.cur_p1 !== 4'd0) begin
      bad++; $display("FAIL reset_state: mem=%0d cur=%0d expected 0/0", dut.mem_p2, dut.cur_p1);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    bit exp[3] = '{0, 1, 0};
    do_reset();
    w = 32'h5; dl = '0; thr = 4'd5; dec = 4'd0; rp = 4'd0;
    for (int k = 0; k < 3; k++) begin
      spk_in = (k == 0) ? 8'h01 : 8'h00;
      step();
      total++;
      if (so0 !== exp[k]) begin
        bad++; $display("FAIL latency step %0d: spike_out=%b expected %b", k, so0, exp[k]);
      end
    end
    total++;
    if (dut.mem_p2 !== 4'd0) begin
      bad++; $display("FAIL latency_mem: mem=%0d expected 0", dut.mem_p2);
    end
  endtask

  task automatic test_delay();
    bit exp_a[6] = '{0, 0, 0, 0, 1, 0};
    bit exp_b[5] = '{0, 0, 1, 0, 0};
    do_reset();
    w = 32'h5; dl = 16'h0003; thr = 4'd5; dec = 4'd0; rp = 4'd0;
    for (int k = 0; k < 6; k++) begin
      spk_in = (k == 0) ? 8'h01 : 8'h00;
      step();
      total++;
      if (so0 !== exp_a[k]) begin
        bad++; $display("FAIL delay3 step %0d: spike_out=%b expected %b", k, so0, exp_a[k]);
      end
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      spk_in = (k == 0) ? 8'h01 : 8'h00;
      dl = (k == 0) ? 16'h0003 : 16'h0001;
      step();
      total++;
      if (so0 !== exp_b[k]) begin
        bad++; $display("FAIL delay_change step %0d: spike_out=%b expected %b", k, so0, exp_b[k]);
      end
    end
    dl = '0;
  endtask

  task automatic test_sat_leak();
    logic [3:0] exp_v[6] = '{4'd7, 4'd5, 4'd3, 4'd1, 4'd0, 4'd0};
    do_reset();
    w = 32'hFFFF_FFFF; dl = '0; thr = 4'd15; dec = 4'd0; rp = 4'd0;
    spk_in = 8'hFF; step();
    total++;
    if (dut.cur_p1 !== 4'd15 || so0 !== 1'b0) begin
      bad++; $display("FAIL sat_current: cur=%0d spike=%b expected 15/0", dut.cur_p1, so0);
    end
    spk_in = 8'h00; step();
    total++;
    if (so0 !== 1'b1 || dut.mem_p2 !== 4'd0) begin
      bad++; $display("FAIL sat_fire: spike=%b mem=%0d expected 1/0", so0, dut.mem_p2);
    end
    w = 32'h9; spk_in = 8'h01; step();
    spk_in = 8'h00; step();
    total++;
    if (dut.mem_p2 !== 4'd9) begin
      bad++; $display("FAIL leak_setup: mem=%0d expected 9", dut.mem_p2);
    end
    dec = 4'd2;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (dut.mem_p2 !== exp_v[k] || so0 !== 1'b0) begin
        bad++; $display("FAIL leak step %0d: mem=%0d spike=%b expected %0d/0", k, dut.mem_p2, so0, exp_v[k]);
      end
    end
    dec = 4'd0;
  endtask

  task automatic test_threshold_zero();
    do_reset();
    w = '0; thr = 4'd0; rp = 4'd0; spk_in = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (so0 !== 1'b1) begin
        bad++; $display("FAIL thr_zero step %0d: spike_out=%b expected 1", k, so0);
      end
    end
  endtask

  task automatic test_refractory();
    bit en_t[11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    bit exp[11]  = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
    do_reset();
    w = 32'hF; dl = '0; thr = 4'd5; dec = 4'd0; rp = 4'd3; spk_in = 8'h01;
    for (int k = 0; k < 11; k++) begin
      en = en_t[k];
      step();
      total++;
      if (so0 !== exp[k] || dut.mem_p2 !== 4'd0) begin
        bad++; $display("FAIL refractory step %0d: spike=%b mem=%0d expected %b/0", k, so0, dut.mem_p2, exp[k]);
      end
    end
    en = 1'b1; rp = 4'd0;
  endtask

  task automatic test_reset_mode1();
    do_reset();
    w = 32'h7; dl = '0; thr = 4'd5; dec = 4'd0; rp = 4'd0;
    spk_in = 8'h01; step();
    spk_in = 8'h00; step();
    total++;
    if (so1 !== 1'b1 || dut1.mem_p2 !== 4'd2) begin
      bad++; $display("FAIL mode1_fire: spike=%b mem=%0d expected 1/2", so1, dut1.mem_p2);
    end
    total++;
    if (so0 !== 1'b1 || dut.mem_p2 !== 4'd0) begin
      bad++; $display("FAIL mode0_fire: spike=%b mem=%0d expected 1/0", so0, dut.mem_p2);
    end
    step();
    total++;
    if (so1 !== 1'b0 || dut1.mem_p2 !== 4'd2) begin
      bad++; $display("FAIL mode1_hold: spike=%b mem=%0d expected 0/2", so1, dut1.mem_p2);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    w = 32'hFF; dl = 16'h000C; thr = 4'd5; dec = 4'd0; rp = 4'd3; spk_in = 8'h03;
    repeat (3) step();
    rst = 1'b1; en = 1'b1;
    step();
    total++;
    if (so0 !== 1'b0 || so1 !== 1'b0 || dut.mem_p2 !== 4'd0 || dut.cur_p1 !== 4'd0) begin
      bad++; $display("FAIL midflight_reset: spike=%b/%b mem=%0d cur=%0d expected all 0",
                      so0, so1, dut.mem_p2, dut.cur_p1);
    end
    rst = 1'b0; spk_in = 8'h00;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (so0 !== 1'b0 || so1 !== 1'b0) begin
        bad++; $display("FAIL midflight_history step %0d: spike=%b/%b expected 0/0", k, so0, so1);
      end
    end
    dl = '0; rp = 4'd0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (k % 25 == 0) begin
        w   = $urandom;
        thr = 4'($urandom_range(0, 15));
        dec = 4'($urandom_range(0, 15));
        rp  = 4'($urandom_range(0, 4));
      end
      if (k % 7 == 0) dl = 16'($urandom);
      spk_in = 8'($urandom);
      en     = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 49) == 0);
      step();
      total++;
      if (so0 !== m_spk[0] || so1 !== m_spk[1]) begin
        bad++; $display("FAIL random_spike cycle %0d: got %b/%b expected %b/%b", k, so0, so1, m_spk[0], m_spk[1]);
      end
      total++;
      if (dut.mem_p2 !== 4'(m_v[0]) || dut1.mem_p2 !== 4'(m_v[1]) || dut.cur_p1 !== 4'(m_cur)) begin
        bad++; $display("FAIL random_state cycle %0d: mem=%0d/%0d cur=%0d expected %0d/%0d/%0d",
                        k, dut.mem_p2, dut1.mem_p2, dut.cur_p1, m_v[0], m_v[1], m_cur);
      end
    end
    rst = 1'b0; en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spk_in = '0; w = '0; dl = '0;
    thr = '0; dec = '0; rp = '0;
    test_reset();
    test_latency();
    test_delay();
    test_sat_leak();
    test_threshold_zero();
    test_refractory();
    test_reset_mode1();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
